// File: rtl/ecc_pkg.sv
// Shared SECDED helpers for the encoder and decoder: codeword geometry and bit placement.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package ecc_pkg;

  // Smallest Hamming parity count r with 2^r >= data_w + r + 1.
  function automatic int ham_r(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  // Full codeword width: data, Hamming parities and the overall parity bit.
  function automatic int cw_w(input int data_w);
    return data_w + ham_r(data_w) + 1;
  endfunction

  // Positions 1, 2, 4, ... carry Hamming parities; position 0 is overall parity.
  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bit index held at a non-parity codeword position: skip position 0
  // and every power-of-two position at or below pos.
  function automatic int data_idx(input int pos);
    int n_par;
    n_par = 0;
    for (int k = 0; k < 31; k++)
      if ((1 << k) <= pos) n_par++;
    return pos - 1 - n_par;
  endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// Hamming parity generator: parity k is the XOR of data bits whose codeword position has bit k set.
// Latency: combinational.
// Backpressure: none (pure function of data).
module ecc_parity_gen
  import ecc_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]        data,
  output logic [ham_r(DATA_W)-1:0] par
);

  localparam int HAM_R = ham_r(DATA_W);
  localparam int CW_W  = cw_w(DATA_W);

  // Fold every data bit into each parity whose index bit is set in its position.
  always_comb begin
    par = '0;
    for (int k = 0; k < HAM_R; k++)
      for (int pos = 3; pos < CW_W; pos++)
        if (!is_pow2(pos) && pos[k])
          par[k] = par[k] ^ data[data_idx(pos)];
  end

endmodule

// File: rtl/ecc_encoder_pipe.sv
// SECDED (extended Hamming) encoder with per-word XOR error injection and delivery counters.
// Latency: PIPE_STAGES cycles (1 or 2) from input acceptance to output valid, one word per cycle.
// Backpressure: valid/ready; stalled output holds steady, in_ready drops once every stage is full.
module ecc_encoder_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [cw_w(DATA_W)-1:0]  in_inj_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [cw_w(DATA_W)-1:0]  out_cw,
  output logic [CNT_W-1:0]         enc_cnt,
  output logic [CNT_W-1:0]         inj_cnt
);

  localparam int HAM_R = ham_r(DATA_W);
  localparam int RED_W = HAM_R + 1;
  localparam int CW_W  = DATA_W + RED_W;

  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("ecc_encoder_pipe: PIPE_STAGES must be 1 or 2");
  end

  // Place data and Hamming parities, then set bit 0 for even overall parity.
  function automatic logic [CW_W-1:0] assemble(input logic [DATA_W-1:0] d,
                                               input logic [HAM_R-1:0]  p);
    logic [CW_W-1:0] cw;
    cw = '0;
    for (int pos = 1; pos < CW_W; pos++)
      if (!is_pow2(pos)) cw[pos] = d[data_idx(pos)];
    for (int k = 0; k < HAM_R; k++)
      cw[1 << k] = p[k];
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  logic             rdy_q;
  logic             stage_rdy;
  logic             out_adv;
  logic             in_xfer;
  logic             ld_vld;
  logic             ld_inj;
  logic [CW_W-1:0]  ld_cw;
  logic [HAM_R-1:0] in_par;
  logic             out_inj;

  ecc_parity_gen #(.DATA_W(DATA_W)) u_parity (
    .data (in_data),
    .par  (in_par)
  );

  assign out_adv  = !out_valid || out_ready;
  assign in_ready = rdy_q && stage_rdy;
  assign in_xfer  = in_valid && in_ready;

  // Keep in_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  if (PIPE_STAGES == 2) begin : g_two
    logic              s1_vld;
    logic [DATA_W-1:0] s1_data;
    logic [CW_W-1:0]   s1_mask;
    logic [HAM_R-1:0]  s1_par;

    assign stage_rdy = !s1_vld || out_adv;
    assign ld_vld    = s1_vld;
    assign ld_cw     = assemble(s1_data, s1_par) ^ s1_mask;
    assign ld_inj    = |s1_mask;

    // Stage 1: capture payload, mask and Hamming parities of each accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld  <= 1'b0;
        s1_data <= '0;
        s1_mask <= '0;
        s1_par  <= '0;
      end else begin
        if (stage_rdy) s1_vld <= in_xfer;
        if (in_xfer) begin
          s1_data <= in_data;
          s1_mask <= in_inj_mask;
          s1_par  <= in_par;
        end
      end
    end
  end else begin : g_one
    assign stage_rdy = out_adv;
    assign ld_vld    = in_xfer;
    assign ld_cw     = assemble(in_data, in_par) ^ in_inj_mask;
    assign ld_inj    = |in_inj_mask;
  end

  // Output stage: take the next finished codeword when empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cw    <= '0;
      out_inj   <= 1'b0;
    end else if (out_adv) begin
      out_valid <= ld_vld;
      if (ld_vld) begin
        out_cw  <= ld_cw;
        out_inj <= ld_inj;
      end
    end
  end

  // Saturating delivery counters, stepped on each output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt <= '0;
      inj_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (enc_cnt != '1)            enc_cnt <= enc_cnt + CNT_W'(1);
      if (out_inj && inj_cnt != '1) inj_cnt <= inj_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ecc_encoder_pipe.sv
module tb_ecc_encoder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference: syndrome is the XOR of the positions of all set bits (position 0 excluded).
  function automatic logic [7:0] syndrome(input logic [255:0] cw);
    logic [7:0] s;
    s = '0;
    for (int p = 1; p < 256; p++)
      if (cw[p]) s = s ^ 8'(p);
    return s;
  endfunction

  // Reference encoder: place data at non-power-of-two positions, choose parities so the
  // syndrome vanishes, then make the whole word even parity, then apply the mask.
  function automatic logic [255:0] ref_cw(input int dw, input logic [255:0] d, input logic [255:0] m);
    int r, n, j;
    logic [255:0] cw;
    logic [7:0] syn;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    n = dw + r + 1;
    cw = '0;
    j = 0;
    for (int p = 1; p < n; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    syn = syndrome(cw);
    for (int k = 0; k < r; k++) cw[1 << k] = syn[k];
    cw[0] = ^cw;
    return cw ^ m;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Instance A: DATA_W=4, two stages, 4-bit counters.
  logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic [3:0] a_in_data = '0, a_enc_cnt, a_inj_cnt;
  logic [7:0] a_in_inj_mask = '0, a_out_cw;

  ecc_encoder_pipe #(.DATA_W(4), .PIPE_STAGES(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_inj_mask(a_in_inj_mask),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_cw(a_out_cw),
    .enc_cnt(a_enc_cnt), .inj_cnt(a_inj_cnt)
  );

  // Instances B (two stages) and C (one stage): DATA_W=64, shared input stream.
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_rand_rdy = 0;
  logic [63:0] b_in_data = '0;
  logic [71:0] b_in_inj_mask = '0, b_out_cw;
  logic [31:0] b_enc_cnt, b_inj_cnt;
  logic        c_in_ready, c_out_valid;
  logic [71:0] c_out_cw;
  logic [31:0] c_enc_cnt, c_inj_cnt;

  ecc_encoder_pipe #(.DATA_W(64), .PIPE_STAGES(2), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inj_mask(b_in_inj_mask),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cw(b_out_cw),
    .enc_cnt(b_enc_cnt), .inj_cnt(b_inj_cnt)
  );

  ecc_encoder_pipe #(.DATA_W(64), .PIPE_STAGES(1), .CNT_W(32)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(c_in_ready), .in_data(b_in_data), .in_inj_mask(b_in_inj_mask),
    .out_valid(c_out_valid), .out_ready(b_out_ready), .out_cw(c_out_cw),
    .enc_cnt(c_enc_cnt), .inj_cnt(c_inj_cnt)
  );

  // Scoreboards: inputs change just after posedge, so a handshake seen at negedge
  // is the transfer that completes at the following posedge.
  logic [255:0] a_q[$], b_q[$], b_mq[$], c_q[$], c_mq[$];
  logic         a_iq[$];
  logic [255:0] b_e, b_m, c_e, c_m;
  int a_out_n = 0, a_inj_n = 0, b_out_n = 0, b_inj_n = 0, c_out_n = 0, c_inj_n = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_q.delete(); a_iq.delete(); a_out_n = 0; a_inj_n = 0;
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) check_eq("a_unexpected_out", 1, 0);
        else begin
          check_eq("a_cw", a_out_cw, a_q.pop_front());
          a_out_n++;
          if (a_iq.pop_front()) a_inj_n++;
        end
      end
      if (a_in_valid && a_in_ready) begin
        a_q.push_back(ref_cw(4, 256'(a_in_data), 256'(a_in_inj_mask)));
        a_iq.push_back(a_in_inj_mask != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_q.delete(); b_mq.delete(); b_out_n = 0; b_inj_n = 0;
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) check_eq("b_unexpected_out", 1, 0);
        else begin
          b_e = b_q.pop_front();
          b_m = b_mq.pop_front();
          check_eq("b_cw", b_out_cw, b_e);
          check_eq("b_syndrome", syndrome(256'(b_out_cw) ^ b_m), 0);
          check_eq("b_parity", ^(256'(b_out_cw) ^ b_m), 0);
          b_out_n++;
          if (b_m != 0) b_inj_n++;
        end
      end
      if (b_in_valid && b_in_ready) begin
        b_q.push_back(ref_cw(64, 256'(b_in_data), 256'(b_in_inj_mask)));
        b_mq.push_back(256'(b_in_inj_mask));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      c_q.delete(); c_mq.delete(); c_out_n = 0; c_inj_n = 0;
    end else begin
      if (c_out_valid && b_out_ready) begin
        if (c_q.size() == 0) check_eq("c_unexpected_out", 1, 0);
        else begin
          c_e = c_q.pop_front();
          c_m = c_mq.pop_front();
          check_eq("c_cw", c_out_cw, c_e);
          check_eq("c_syndrome", syndrome(256'(c_out_cw) ^ c_m), 0);
          c_out_n++;
          if (c_m != 0) c_inj_n++;
        end
      end
      if (b_in_valid && c_in_ready) begin
        c_q.push_back(ref_cw(64, 256'(b_in_data), 256'(b_in_inj_mask)));
        c_mq.push_back(256'(b_in_inj_mask));
      end
    end
  end

  // Random downstream readiness for B and C.
  always @(posedge clk) begin
    #1;
    if (b_rand_rdy) b_out_ready = 1'($urandom_range(1));
  end

  // One word through A with out_ready high; checks exact latency and value.
  task automatic a_send(input logic [3:0] d, input logic [7:0] m, input logic [7:0] exp, input string tag);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = d; a_in_inj_mask = m;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check_eq({tag, "_not_early"}, a_out_valid, 0);
    @(posedge clk); #1;
    check_eq({tag, "_out_valid"}, a_out_valid, 1);
    check_eq({tag, "_out_cw"}, a_out_cw, exp);
    @(posedge clk); #1;
    check_eq({tag, "_consumed"}, a_out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, t;
    logic took, stale;
    logic [71:0] bm;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_a_out_valid", a_out_valid, 0);
    check_eq("rst_a_out_cw", a_out_cw, 0);
    check_eq("rst_a_in_ready", a_in_ready, 0);
    check_eq("rst_a_enc_cnt", a_enc_cnt, 0);
    check_eq("rst_a_inj_cnt", a_inj_cnt, 0);
    check_eq("rst_b_in_ready", b_in_ready, 0);
    check_eq("rst_c_out_valid", c_out_valid, 0);
    #2 rst_n = 1'b1;
    #1 check_eq("rel_a_in_ready_low", a_in_ready, 0);
    @(posedge clk); #1;
    check_eq("rel_a_in_ready_up", a_in_ready, 1);

    // Directed vectors on the 4-bit encoder.
    a_send(4'hB, 8'h00, 8'hAA, "vec_b");
    check_eq("vec_b_enc_cnt", a_enc_cnt, 1);
    check_eq("vec_b_inj_cnt", a_inj_cnt, 0);
    a_send(4'hF, 8'h00, 8'hFF, "vec_f");
    a_send(4'h0, 8'h00, 8'h00, "vec_0");
    a_send(4'hB, 8'h01, 8'hAB, "vec_inj");
    check_eq("vec_inj_inj_cnt", a_inj_cnt, 1);
    check_eq("vec_inj_enc_cnt", a_enc_cnt, 4);

    // 20 back-to-back words: no bubbles, counters saturate.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1;
      a_in_data = 4'($urandom);
      a_in_inj_mask = ($urandom_range(1) == 1) ? 8'($urandom) : 8'h00;
      @(negedge clk);
      check_eq("b2b_in_ready", a_in_ready, 1);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("b2b_drained", a_q.size(), 0);
    check_eq("b2b_out_count", a_out_n, 24);
    check_eq("sat_enc_cnt", a_enc_cnt, sat15(a_out_n));
    check_eq("sat_inj_cnt", a_inj_cnt, sat15(a_inj_n));

    // Backpressure: out_ready low for 10 cycles with input always offered.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 4'($urandom);
    a_in_inj_mask = 8'h00;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      took = a_in_valid && a_in_ready;
      if (took) acc++;
      if (a_out_valid) check_eq("bp_hold_cw", a_out_cw, a_q[0]);
      @(posedge clk); #1;
      if (took) a_in_data = 4'($urandom);
    end
    check_eq("bp_accepts", acc, 2);
    check_eq("bp_in_ready_low", a_in_ready, 0);
    check_eq("bp_out_valid_held", a_out_valid, 1);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    t = 0;
    while (a_q.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("bp_drain", a_q.size(), 0);

    // Random traffic on the 64-bit encoders with random downstream readiness.
    b_rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      bm = '0;
      if ($urandom_range(3) == 0) bm[$urandom_range(71)] = 1'b1;
      b_in_valid = 1'b1;
      b_in_data = {$urandom, $urandom};
      b_in_inj_mask = bm;
      t = 0;
      @(negedge clk);
      while (!b_in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) check_eq("b_accept_timeout", 0, 1);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_rand_rdy = 1'b0;
    b_out_ready = 1'b1;
    t = 0;
    while ((b_q.size() != 0 || c_q.size() != 0) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("rand_drain", b_q.size() + c_q.size(), 0);
    check_eq("b_word_count", b_out_n, 1000);
    check_eq("b_enc_cnt", b_enc_cnt, b_out_n);
    check_eq("b_inj_cnt", b_inj_cnt, b_inj_n);
    check_eq("c_enc_cnt", c_enc_cnt, c_out_n);
    check_eq("c_inj_cnt", c_inj_cnt, c_inj_n);

    // Reset with two words in flight in A.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 4'h5;
    @(posedge clk); #1;
    a_in_data = 4'h6;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check_eq("mid_rst_pre_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", a_out_valid, 0);
    check_eq("mid_rst_out_cw", a_out_cw, 0);
    check_eq("mid_rst_in_ready", a_in_ready, 0);
    check_eq("mid_rst_enc_cnt", a_enc_cnt, 0);
    check_eq("mid_rst_inj_cnt", a_inj_cnt, 0);
    check_eq("mid_rst_b_enc_cnt", b_enc_cnt, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      stale = stale | a_out_valid;
    end
    check_eq("post_rst_no_stale", stale, 0);
    check_eq("post_rst_enc_cnt", a_enc_cnt, 0);
    a_send(4'hB, 8'h00, 8'hAA, "post_rst");
    check_eq("post_rst_enc_one", a_enc_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
